// File: rtl/link_recovery_ctrl.sv
// link_recovery_ctrl: per-lane link bring-up and recovery sequencer.
// Waits for gt_ready, qualifies channel_good over GOOD_FILTER consecutive
// cycles, recovers lock timeouts with bounded datapath-reset pulses and
// escalates to a transceiver reset after MAX_RETRIES failed attempts.
// Optional build macro: LINK_RECOVERY_STATS_EN adds link_loss_count and
// gt_reset_count saturating statistics outputs.
module link_recovery_ctrl #(
    parameter int unsigned TIMEOUT_WIDTH    = 16,
    parameter int unsigned MAX_RETRIES      = 4,
    parameter int unsigned RST_PULSE_CYCLES = 8,
    parameter int unsigned GOOD_FILTER      = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               gt_ready,
    input  logic                               channel_good,
    output logic                               dp_rst_out,
    output logic                               gt_rst_out,
    output logic                               link_up,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
    output logic [2:0]                         ctrl_state
`ifdef LINK_RECOVERY_STATS_EN
    ,
    output logic [15:0]                        link_loss_count,
    output logic [15:0]                        gt_reset_count
`endif
);

    localparam int unsigned RW = $clog2(MAX_RETRIES + 1);
    localparam int unsigned PW = $clog2(RST_PULSE_CYCLES + 1);
    localparam int unsigned GW = $clog2(GOOD_FILTER + 1);

    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);
    localparam logic [PW-1:0] PULSE_LAST  = PW'(RST_PULSE_CYCLES - 1);
    localparam logic [GW-1:0] GOOD_LAST   = GW'(GOOD_FILTER - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOCK = 3'd1,
        UP        = 3'd2,
        DP_RST    = 3'd3,
        GT_RST    = 3'd4
    } state_t;

    state_t                   state;
    logic [TIMEOUT_WIDTH-1:0] lock_timer;
    logic [GW-1:0]            good_cnt;
    logic [PW-1:0]            pulse_cnt;

    assign ctrl_state = state;

    // Sequencer FSM with registered outputs and all per-state counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            lock_timer      <= '0;
            good_cnt        <= '0;
            pulse_cnt       <= '0;
            retry_count     <= '0;
            link_up         <= 1'b0;
            dp_rst_out      <= 1'b0;
            gt_rst_out      <= 1'b0;
`ifdef LINK_RECOVERY_STATS_EN
            link_loss_count <= '0;
            gt_reset_count  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    link_up    <= 1'b0;
                    dp_rst_out <= 1'b0;
                    gt_rst_out <= 1'b0;
                    if (gt_ready) begin
                        state      <= WAIT_LOCK;
                        lock_timer <= '0;
                        good_cnt   <= '0;
                    end
                end

                WAIT_LOCK: begin
                    if (!gt_ready) begin
                        state <= IDLE;
                    end else if (channel_good && (good_cnt == GOOD_LAST)) begin
                        // Lock completion takes priority over a coincident timeout
                        state       <= UP;
                        link_up     <= 1'b1;
                        retry_count <= '0;
                    end else if (lock_timer[TIMEOUT_WIDTH-1]) begin
                        pulse_cnt <= '0;
                        if (retry_count < RETRY_LIMIT) begin
                            state       <= DP_RST;
                            dp_rst_out  <= 1'b1;
                            retry_count <= retry_count + 1'b1;
                        end else begin
                            state       <= GT_RST;
                            gt_rst_out  <= 1'b1;
                            retry_count <= '0;
`ifdef LINK_RECOVERY_STATS_EN
                            if (gt_reset_count != '1)
                                gt_reset_count <= gt_reset_count + 1'b1;
`endif
                        end
                    end else begin
                        lock_timer <= lock_timer + 1'b1;
                        good_cnt   <= channel_good ? good_cnt + 1'b1 : '0;
                    end
                end

                UP: begin
                    if (!gt_ready) begin
                        state   <= IDLE;
                        link_up <= 1'b0;
                    end else if (!channel_good) begin
                        state      <= WAIT_LOCK;
                        link_up    <= 1'b0;
                        lock_timer <= '0;
                        good_cnt   <= '0;
`ifdef LINK_RECOVERY_STATS_EN
                        if (link_loss_count != '1)
                            link_loss_count <= link_loss_count + 1'b1;
`endif
                    end
                end

                DP_RST: begin
                    if (!gt_ready) begin
                        state      <= IDLE;
                        dp_rst_out <= 1'b0;
                    end else if (pulse_cnt == PULSE_LAST) begin
                        state      <= WAIT_LOCK;
                        dp_rst_out <= 1'b0;
                        lock_timer <= '0;
                        good_cnt   <= '0;
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end

                GT_RST: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        state      <= IDLE;
                        gt_rst_out <= 1'b0;
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    link_up    <= 1'b0;
                    dp_rst_out <= 1'b0;
                    gt_rst_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_link_recovery_ctrl.sv
// Scoreboard bench for link_recovery_ctrl: the stimulus pushes expected
// output-change events (edge index + output tuple); a forked monitor pops
// and compares whenever the DUT output tuple changes.
module tb_link_recovery_ctrl;

    localparam int TW  = 6;
    localparam int MR  = 2;
    localparam int RP  = 4;
    localparam int GF  = 8;
    localparam int RCW = $clog2(MR + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           gt_ready = 1'b1;
    logic           channel_good = 1'b0;
    logic           dp_rst_out;
    logic           gt_rst_out;
    logic           link_up;
    logic [RCW-1:0] retry_count;
    logic [2:0]     ctrl_state;
`ifdef LINK_RECOVERY_STATS_EN
    logic [15:0]    link_loss_count;
    logic [15:0]    gt_reset_count;
`endif

    link_recovery_ctrl #(
        .TIMEOUT_WIDTH    (TW),
        .MAX_RETRIES      (MR),
        .RST_PULSE_CYCLES (RP),
        .GOOD_FILTER      (GF)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .gt_ready        (gt_ready),
        .channel_good    (channel_good),
        .dp_rst_out      (dp_rst_out),
        .gt_rst_out      (gt_rst_out),
        .link_up         (link_up),
        .retry_count     (retry_count),
        .ctrl_state      (ctrl_state)
`ifdef LINK_RECOVERY_STATS_EN
        ,
        .link_loss_count (link_loss_count),
        .gt_reset_count  (gt_reset_count)
`endif
    );

    always #5 clk = ~clk;

    // Rising-edge index since reset release
    int cyc = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        int             c;
        logic [2:0]     st;
        logic           lu;
        logic           dp;
        logic           gt;
        logic [RCW-1:0] rc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [7:0] out_tuple();
        return {ctrl_state, link_up, dp_rst_out, gt_rst_out, retry_count};
    endfunction

    function automatic void expect_ev(int c, logic [2:0] st, logic lu, logic dp,
                                      logic gt, logic [RCW-1:0] rc);
        exp_t e;
        e.c = c; e.st = st; e.lu = lu; e.dp = dp; e.gt = gt; e.rc = rc;
        sb.push_back(e);
    endfunction

    function automatic void check_val(string name, int got, int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endfunction

    task automatic monitor();
        logic [7:0] last;
        logic [7:0] cur;
        exp_t       e;
        last = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last = '0;
            end else begin
                cur = out_tuple();
                if (cur !== last) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_change cyc=%0d got state=%0d link_up=%0b dp=%0b gt=%0b retry=%0d, required no change",
                                 cyc, cur[7:5], cur[4], cur[3], cur[2], cur[1:0]);
                    end else begin
                        e = sb.pop_front();
                        if (cyc != e.c || cur !== {e.st, e.lu, e.dp, e.gt, e.rc}) begin
                            errors++;
                            $display("FAIL event: got cyc=%0d state=%0d link_up=%0b dp=%0b gt=%0b retry=%0d, required cyc=%0d state=%0d link_up=%0b dp=%0b gt=%0b retry=%0d",
                                     cyc, cur[7:5], cur[4], cur[3], cur[2], cur[1:0],
                                     e.c, e.st, e.lu, e.dp, e.gt, e.rc);
                        end
                    end
                    last = cur;
                end
            end
        end
    endtask

    // Wait (bounded) until the negedge following rising edge c
    task automatic wait_until(int c);
        int guard;
        guard = 0;
        while (cyc < c && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != c) begin
            checks++;
            errors++;
            $display("FAIL wait_until: got cyc %0d required %0d", cyc, c);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check_val("reset_outputs", int'(out_tuple()), 0);
        #1 rst = 1'b0;

        // Clean bring-up: 8 good samples at edges 5..12
        expect_ev(1,  3'd1, 1'b0, 1'b0, 1'b0, 2'd0);
        expect_ev(12, 3'd2, 1'b1, 1'b0, 1'b0, 2'd0);
        wait_until(4);   channel_good = 1'b1;

        // Link loss: one low sample, then relock after 8 good samples
        expect_ev(21, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0);
        expect_ev(29, 3'd2, 1'b1, 1'b0, 1'b0, 2'd0);
        wait_until(20);  channel_good = 1'b0;
        wait_until(21);  channel_good = 1'b1;

        // Filter glitch: 7 high, 1 low, 8 high
        expect_ev(36, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0);
        expect_ev(52, 3'd2, 1'b1, 1'b0, 1'b0, 2'd0);
        wait_until(35);  channel_good = 1'b0;
        wait_until(36);  channel_good = 1'b1;
        wait_until(43);  channel_good = 1'b0;
        wait_until(44);  channel_good = 1'b1;

        // gt_ready drop while up, then relock
        expect_ev(56, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        expect_ev(58, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0);
        expect_ev(66, 3'd2, 1'b1, 1'b0, 1'b0, 2'd0);
        wait_until(55);  gt_ready = 1'b0;
        wait_until(57);  gt_ready = 1'b1;

        // Escalation: two dp resets, then gt reset, IDLE, WAIT_LOCK
        expect_ev(71,  3'd1, 1'b0, 1'b0, 1'b0, 2'd0);
        expect_ev(104, 3'd3, 1'b0, 1'b1, 1'b0, 2'd1);
        expect_ev(108, 3'd1, 1'b0, 1'b0, 1'b0, 2'd1);
        expect_ev(141, 3'd3, 1'b0, 1'b1, 1'b0, 2'd2);
        expect_ev(145, 3'd1, 1'b0, 1'b0, 1'b0, 2'd2);
        expect_ev(178, 3'd4, 1'b0, 1'b0, 1'b1, 2'd0);
        expect_ev(182, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        expect_ev(183, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0);
        wait_until(70);  channel_good = 1'b0;

        // Retry count holds across a gt_ready drop in WAIT_LOCK
        expect_ev(216, 3'd3, 1'b0, 1'b1, 1'b0, 2'd1);
        expect_ev(220, 3'd1, 1'b0, 1'b0, 1'b0, 2'd1);
        expect_ev(226, 3'd0, 1'b0, 1'b0, 1'b0, 2'd1);
        expect_ev(228, 3'd1, 1'b0, 1'b0, 1'b0, 2'd1);
        expect_ev(261, 3'd3, 1'b0, 1'b1, 1'b0, 2'd2);
        wait_until(225); gt_ready = 1'b0;
        wait_until(227); gt_ready = 1'b1;

        // Asynchronous reset in the second cycle of a dp reset pulse
        wait_until(262);
`ifdef LINK_RECOVERY_STATS_EN
        check_val("link_loss_count", int'(link_loss_count), 3);
        check_val("gt_reset_count", int'(gt_reset_count), 1);
`endif
        check_val("dp_pulse_cycle2", int'(dp_rst_out), 1);
        #1 rst = 1'b1;
        #1;
        check_val("async_reset_outputs", int'(out_tuple()), 0);
`ifdef LINK_RECOVERY_STATS_EN
        check_val("stats_after_reset", int'({link_loss_count, gt_reset_count}), 0);
`endif

        // Restart after reset
        channel_good = 1'b0;
        repeat (2) @(negedge clk);
        expect_ev(1, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0);
        #1 rst = 1'b0;
        wait_until(6);
        check_val("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
